hazard_unit: RTL and testbench

Backward-path control for the 5-stage pipelined CPU. It tracks the destination registers of in-flight instructions in a private shadow pipeline covering the EX and MEM stages. From that state it produces three kinds of control for the RF stage: operand-forwarding selects, flag-forwarding select, and a load-use stall. The stall freezes the IF and IF→RF registers and inserts a bubble into the RF→EX register. The regfile writes on the inverted clock, so WB-to-RF needs no forwarding.

---
 rtl/hazard_unit.sv | 132 +++++++++++++
 tb/tb_hazard_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : hazard_unit                                                |
// | Brief    : RF-stage forwarding, flag-forwarding and load-use stall.   |
// |            Optional HAZARD_STATS_EN adds stall/forward counters.     |
// | Revision : 1.0                                                      |
// +----------------------------------------------------------------------+
module hazard_unit #(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic             id_reg_write,
  input  logic             id_load,
  input  logic             id_set_flag,
  input  logic             id_uses_flags,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             flag_sel,
  output logic             stall
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      fwd_cnt
`endif
);

  localparam logic [REG_W-1:0] c_zero     = REG_W'(ZERO_REG);
  localparam logic [1:0]       c_sel_rf   = 2'b00;
  localparam logic [1:0]       c_sel_ex   = 2'b01;
  localparam logic [1:0]       c_sel_mem  = 2'b10;

  logic             r_ex_valid, r_ex_reg_write, r_ex_load, r_ex_set_flag;
  logic [REG_W-1:0] r_ex_rd;
  logic             r_mem_valid, r_mem_reg_write, r_mem_load, r_mem_set_flag;
  logic [REG_W-1:0] r_mem_rd;

  logic             w_ex_wr_rn, w_ex_wr_rm, w_mem_wr_rn, w_mem_wr_rm;
  logic [1:0]       w_fwd_a, w_fwd_b;
  logic             w_stall, w_flag_sel;

  function automatic logic stage_writes(input logic v, input logic rw,
                                        input logic [REG_W-1:0] rd,
                                        input logic [REG_W-1:0] r);
    return v & rw & (rd == r) & (r != c_zero);
  endfunction

  always_comb begin
    w_ex_wr_rn  = stage_writes(r_ex_valid,  r_ex_reg_write,  r_ex_rd,  id_rn);
    w_ex_wr_rm  = stage_writes(r_ex_valid,  r_ex_reg_write,  r_ex_rd,  id_rm);
    w_mem_wr_rn = stage_writes(r_mem_valid, r_mem_reg_write, r_mem_rd, id_rn);
    w_mem_wr_rm = stage_writes(r_mem_valid, r_mem_reg_write, r_mem_rd, id_rm);

    // EX is checked first: it holds the youngest producer of the register.
    w_fwd_a = c_sel_rf;
    if (id_uses_rn && w_ex_wr_rn)       w_fwd_a = c_sel_ex;
    else if (id_uses_rn && w_mem_wr_rn) w_fwd_a = c_sel_mem;

    w_fwd_b = c_sel_rf;
    if (id_uses_rm && w_ex_wr_rm)       w_fwd_b = c_sel_ex;
    else if (id_uses_rm && w_mem_wr_rm) w_fwd_b = c_sel_mem;

    w_stall    = id_valid & r_ex_load &
                 ((id_uses_rn & w_ex_wr_rn) | (id_uses_rm & w_ex_wr_rm));
    w_flag_sel = id_valid & id_uses_flags & r_ex_valid & r_ex_set_flag;
  end

  assign fwd_a    = reset ? c_sel_rf : w_fwd_a;
  assign fwd_b    = reset ? c_sel_rf : w_fwd_b;
  assign stall    = reset ? 1'b0     : w_stall;
  assign flag_sel = reset ? 1'b0     : w_flag_sel;

  // Shadow pipeline; a stall leaves a bubble in EX while MEM keeps advancing.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_valid      <= 1'b0;
      r_ex_reg_write  <= 1'b0;
      r_ex_load       <= 1'b0;
      r_ex_set_flag   <= 1'b0;
      r_ex_rd         <= '0;
      r_mem_valid     <= 1'b0;
      r_mem_reg_write <= 1'b0;
      r_mem_load      <= 1'b0;
      r_mem_set_flag  <= 1'b0;
      r_mem_rd        <= '0;
    end else begin
      r_mem_valid     <= r_ex_valid;
      r_mem_reg_write <= r_ex_reg_write;
      r_mem_load      <= r_ex_load;
      r_mem_set_flag  <= r_ex_set_flag;
      r_mem_rd        <= r_ex_rd;
      if (w_stall) begin
        r_ex_valid <= 1'b0;
      end else begin
        r_ex_valid     <= id_valid;
        r_ex_reg_write <= id_reg_write;
        r_ex_load      <= id_load;
        r_ex_set_flag  <= id_set_flag;
        r_ex_rd        <= id_rd;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stall_cnt, r_fwd_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (id_valid && !w_stall && ((w_fwd_a != c_sel_rf) || (w_fwd_b != c_sel_rf)) &&
          (r_fwd_cnt != 32'hFFFF_FFFF))
        r_fwd_cnt <= r_fwd_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign fwd_cnt   = r_fwd_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_hazard_unit                                             |
// | Brief    : Directed self-checking bench for hazard_unit.              |
// | Revision : 1.0                                                      |
// +----------------------------------------------------------------------+
module tb_hazard_unit;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rn, id_rm, id_rd;
  logic       id_uses_rn, id_uses_rm, id_reg_write, id_load, id_set_flag, id_uses_flags;
  logic [1:0] fwd_a, fwd_b;
  logic       flag_sel, stall;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, fwd_cnt;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  hazard_unit #(.REG_W(5), .ZERO_REG(31)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rn        (id_rn),
    .id_rm        (id_rm),
    .id_rd        (id_rd),
    .id_uses_rn   (id_uses_rn),
    .id_uses_rm   (id_uses_rm),
    .id_reg_write (id_reg_write),
    .id_load      (id_load),
    .id_set_flag  (id_set_flag),
    .id_uses_flags(id_uses_flags),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .flag_sel     (flag_sel),
    .stall        (stall)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt    (stall_cnt),
    .fwd_cnt      (fwd_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one RF-stage instruction; flags: valid, uses_rn, uses_rm, reg_write, load, set_flag, uses_flags.
  task automatic drive(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                       input logic [4:0] rd, input logic urn, input logic urm,
                       input logic rw, input logic ld, input logic sf, input logic uf);
    id_valid = v; id_rn = rn; id_rm = rm; id_rd = rd;
    id_uses_rn = urn; id_uses_rm = urm; id_reg_write = rw;
    id_load = ld; id_set_flag = sf; id_uses_flags = uf;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic flush();
    nop(); step(); step();
  endtask

  task automatic do_reset();
    reset = 1'b1; nop(); step(); step(); reset = 1'b0; #1;
  endtask

  task automatic test_reset();
    do_reset();
    // reader of X1 straight after reset: shadow must be empty
    drive(1'b1, 5'd1, 5'd1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    total_cnt++;
    if ({fwd_a, fwd_b, stall, flag_sel} !== 6'b0)
      $display("FAIL reset_outputs: got fwd_a=%b fwd_b=%b stall=%b flag_sel=%b want all 0", fwd_a, fwd_b, stall, flag_sel);
    else pass_cnt++;
`ifdef HAZARD_STATS_EN
    total_cnt++;
    if (stall_cnt !== 32'd0 || fwd_cnt !== 32'd0)
      $display("FAIL reset_counters: got stall_cnt=%0d fwd_cnt=%0d want 0 0", stall_cnt, fwd_cnt);
    else pass_cnt++;
`endif
    flush();
  endtask

  task automatic test_ex_fwd();
    drive(1'b1, 5'd2, 5'd3, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); // ADDS X1,X2,X3
    step();
    drive(1'b1, 5'd1, 5'd1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); // ADD X4,X1,X1
    total_cnt++;
    if (fwd_a !== 2'b01 || fwd_b !== 2'b01 || stall !== 1'b0)
      $display("FAIL ex_fwd: got fwd_a=%b fwd_b=%b stall=%b want 01 01 0", fwd_a, fwd_b, stall);
    else pass_cnt++;
    flush();
  endtask

  task automatic test_mem_fwd();
    drive(1'b1, 5'd8, 5'd9, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);   // ADD X5
    step();
    drive(1'b1, 5'd11, 5'd12, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); // unrelated
    step();
    drive(1'b1, 5'd7, 5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);    // SUB X6,X7,X5
    total_cnt++;
    if (fwd_a !== 2'b00 || fwd_b !== 2'b10 || stall !== 1'b0)
      $display("FAIL mem_fwd: got fwd_a=%b fwd_b=%b stall=%b want 00 10 0", fwd_a, fwd_b, stall);
    else pass_cnt++;
    // same reader but operand not used: no forwarding
    drive(1'b1, 5'd7, 5'd5, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (fwd_b !== 2'b00)
      $display("FAIL mem_fwd_unused: got fwd_b=%b want 00", fwd_b);
    else pass_cnt++;
    flush();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 5'd2, 5'd3, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); // ADD X1
    step();
    drive(1'b1, 5'd2, 5'd3, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); // ADD X1
    step();
    drive(1'b1, 5'd9, 5'd1, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); // reader of X1 on rm
    total_cnt++;
    if (fwd_b !== 2'b01 || fwd_a !== 2'b00)
      $display("FAIL youngest_wins: got fwd_a=%b fwd_b=%b want 00 01", fwd_a, fwd_b);
    else pass_cnt++;
    flush();
  endtask

  task automatic test_load_use();
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); // LDUR X3,[X0]
    step();
    drive(1'b1, 5'd3, 5'd2, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); // ADD X4,X3,X2
    total_cnt++;
    if (stall !== 1'b1 || fwd_a !== 2'b01)
      $display("FAIL load_use_c1: got stall=%b fwd_a=%b want 1 01", stall, fwd_a);
    else pass_cnt++;
    step();
    total_cnt++;
    if (stall !== 1'b0 || fwd_a !== 2'b10 || fwd_b !== 2'b00)
      $display("FAIL load_use_c2: got stall=%b fwd_a=%b fwd_b=%b want 0 10 00", stall, fwd_a, fwd_b);
    else pass_cnt++;
    total_cnt++;
    if (dut.r_ex_valid !== 1'b0)
      $display("FAIL load_use_bubble: got ex_valid=%b want 0", dut.r_ex_valid);
    else pass_cnt++;
    step();
    nop();
`ifdef HAZARD_STATS_EN
    total_cnt++;
    if (stall_cnt !== 32'd1 || fwd_cnt !== 32'd1)
      $display("FAIL load_use_stats: got stall_cnt=%0d fwd_cnt=%0d want 1 1", stall_cnt, fwd_cnt);
    else pass_cnt++;
`endif
    // id_valid=0 against a load in EX: no stall
    flush();
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, 5'd3, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (stall !== 1'b0)
      $display("FAIL load_use_invalid: got stall=%b want 0", stall);
    else pass_cnt++;
    flush();
  endtask

  task automatic test_zero_reg();
    drive(1'b1, 5'd1, 5'd2, 5'd31, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); // ADD X31,X1,X2
    step();
    drive(1'b1, 5'd31, 5'd31, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); // ADD X4,X31,X31
    total_cnt++;
    if (fwd_a !== 2'b00 || fwd_b !== 2'b00 || stall !== 1'b0)
      $display("FAIL zero_reg_ex: got fwd_a=%b fwd_b=%b stall=%b want 00 00 0", fwd_a, fwd_b, stall);
    else pass_cnt++;
    step();
    drive(1'b1, 5'd0, 5'd0, 5'd31, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); // LDUR X31
    step();
    drive(1'b1, 5'd31, 5'd31, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (fwd_a !== 2'b00 || fwd_b !== 2'b00 || stall !== 1'b0)
      $display("FAIL zero_reg_load: got fwd_a=%b fwd_b=%b stall=%b want 00 00 0", fwd_a, fwd_b, stall);
    else pass_cnt++;
    step();
    total_cnt++;
    if (fwd_a !== 2'b00 || stall !== 1'b0)
      $display("FAIL zero_reg_mem: got fwd_a=%b stall=%b want 00 0", fwd_a, stall);
    else pass_cnt++;
    flush();
  endtask

  task automatic test_flags();
    drive(1'b1, 5'd2, 5'd3, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); // ADDS
    step();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); // B.cond
    total_cnt++;
    if (flag_sel !== 1'b1)
      $display("FAIL flag_fwd: got flag_sel=%b want 1", flag_sel);
    else pass_cnt++;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    total_cnt++;
    if (flag_sel !== 1'b0)
      $display("FAIL flag_invalid: got flag_sel=%b want 0", flag_sel);
    else pass_cnt++;
    step();
    // ADDS now in MEM, bubble in EX: no live flags
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    total_cnt++;
    if (flag_sel !== 1'b0)
      $display("FAIL flag_mem: got flag_sel=%b want 0", flag_sel);
    else pass_cnt++;
    flush();
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); // LDUR
    step();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    total_cnt++;
    if (flag_sel !== 1'b0)
      $display("FAIL flag_load: got flag_sel=%b want 0", flag_sel);
    else pass_cnt++;
    flush();
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); // LDUR X3
    step();
    drive(1'b1, 5'd2, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1); // reader of X3 on rm
    total_cnt++;
    if (stall !== 1'b1 || fwd_b !== 2'b01)
      $display("FAIL mid_stall_pre: got stall=%b fwd_b=%b want 1 01", stall, fwd_b);
    else pass_cnt++;
    reset = 1'b1; #1;
    total_cnt++;
    if ({fwd_a, fwd_b, stall, flag_sel} !== 6'b0)
      $display("FAIL mid_stall_forced: got fwd_a=%b fwd_b=%b stall=%b flag_sel=%b want all 0", fwd_a, fwd_b, stall, flag_sel);
    else pass_cnt++;
    step();
    reset = 1'b0; #1;
    total_cnt++;
    if ({fwd_a, fwd_b, stall, flag_sel} !== 6'b0)
      $display("FAIL mid_stall_after: got fwd_a=%b fwd_b=%b stall=%b flag_sel=%b want all 0", fwd_a, fwd_b, stall, flag_sel);
    else pass_cnt++;
    flush();
  endtask

  initial begin
    reset = 1'b1;
    nop();
    test_reset();
    test_ex_fwd();
    test_mem_fwd();
    test_back_to_back();
    test_load_use();
    test_zero_reg();
    test_flags();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
